// File: rtl/irrigation_scheduler.sv
// Irrigation cycle sequencer: FILL then SPRAY/DRIP/CLEAN, each state timed by a BCD
// seconds-remaining counter that is driven by a one-second prescaler.
module irrigation_scheduler #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int T_FILL      = 30,
    parameter int T_DRIP      = 40,
    parameter int T_SPRAY     = 20,
    parameter int T_CLEAN     = 15
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       start,
    input  logic       gotejamento,
    input  logic       aspersao,
    input  logic       agro_req,
    input  logic       pause,
    output logic [2:0] state,
    output logic       valve_fill,
    output logic       valve_drip,
    output logic       valve_spray,
    output logic       valve_clean,
    output logic       valve_agro,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRIP  = 3'd2,
        SPRAY = 3'd3,
        CLEAN = 3'd4
    } state_e;

    localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic          agro_q, agro_d;
    logic          done_q, done_d;
    logic [4:0]    valves_q, valves_d;
    logic          tick;
    logic          timerZero;

    // Entry value of the seconds counter for each timed state, in BCD.
    function automatic logic [7:0] loadValue(input state_e s);
        int t;
        case (s)
            FILL:    t = T_FILL;
            DRIP:    t = T_DRIP;
            SPRAY:   t = T_SPRAY;
            CLEAN:   t = T_CLEAN;
            default: t = 0;
        endcase
        return {4'(t / 10), 4'(t % 10)};
    endfunction

    assign tick      = (state_q != IDLE) && !pause && (presc_q == PRESC_MAX);
    assign timerZero = (tens_q == 4'd0) && (units_q == 4'd0);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        units_d = units_q;
        agro_d  = agro_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            presc_d = '0;
            if (start && !pause) begin
                state_d = FILL;
                agro_d  = agro_req;
            end
        end else if (!pause) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        // A tick at 00 ends the state, so each state spans T+1 ticks.
        if (tick && timerZero) begin
            case (state_q)
                FILL: begin
                    if (aspersao)
                        state_d = SPRAY;
                    else if (gotejamento)
                        state_d = DRIP;
                    else
                        state_d = CLEAN;
                end
                DRIP, SPRAY: state_d = CLEAN;
                CLEAN: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    agro_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end else if (tick) begin
            if (units_q == 4'd0) begin
                units_d = 4'd9;
                tens_d  = tens_q - 4'd1;
            end else begin
                units_d = units_q - 4'd1;
            end
        end

        if (state_d != state_q) begin
            {tens_d, units_d} = loadValue(state_d);
            presc_d           = '0;
        end
    end

    always_comb begin
        valves_d = {state_d == FILL,
                    state_d == DRIP,
                    state_d == SPRAY,
                    state_d == CLEAN,
                    (state_d == SPRAY) && agro_d};
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            agro_q   <= 1'b0;
            done_q   <= 1'b0;
            valves_q <= 5'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            agro_q   <= agro_d;
            done_q   <= done_d;
            valves_q <= valves_d;
        end
    end

    // Pause is already synchronous, so gating here shuts every actuator off in the same cycle.
    assign valve_fill  = valves_q[4] & ~pause;
    assign valve_drip  = valves_q[3] & ~pause;
    assign valve_spray = valves_q[2] & ~pause;
    assign valve_clean = valves_q[1] & ~pause;
    assign valve_agro  = valves_q[0] & ~pause;

    assign state     = state_q;
    assign sec_tens  = tens_q;
    assign sec_units = units_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: expected per-cycle output snapshots are queued
// when a cycle is started and compared on every falling edge.
module tb_irrigation_scheduler;

    localparam int CPS = 4;

    typedef logic [17:0] snap_t;

    logic       clk1 = 1'b0;
    logic       reset, start, start2, gotejamento, aspersao, agro_req, pause;
    logic [2:0] state1, state2;
    logic       vf1, vd1, vs1, vc1, va1, busy1, done1;
    logic       vf2, vd2, vs2, vc2, va2, busy2, done2;
    logic [3:0] su1, st1, su2, st2;
    snap_t      snap1, snap2;

    snap_t expQ[$];
    snap_t expQ2[$];
    snap_t tmpQ[$];
    int    compared   = 0;
    int    mismatched = 0;
    string scen       = "init";

    always #5 clk1 = ~clk1;

    irrigation_scheduler #(
        .CLK_PER_SEC(CPS), .T_FILL(2), .T_DRIP(3), .T_SPRAY(2), .T_CLEAN(1)
    ) dut (
        .clk1(clk1), .reset(reset), .start(start), .gotejamento(gotejamento),
        .aspersao(aspersao), .agro_req(agro_req), .pause(pause), .state(state1),
        .valve_fill(vf1), .valve_drip(vd1), .valve_spray(vs1), .valve_clean(vc1),
        .valve_agro(va1), .sec_units(su1), .sec_tens(st1), .busy(busy1), .done(done1)
    );

    irrigation_scheduler #(
        .CLK_PER_SEC(CPS), .T_FILL(2), .T_DRIP(10), .T_SPRAY(2), .T_CLEAN(1)
    ) dutBcd (
        .clk1(clk1), .reset(reset), .start(start2), .gotejamento(gotejamento),
        .aspersao(aspersao), .agro_req(agro_req), .pause(pause), .state(state2),
        .valve_fill(vf2), .valve_drip(vd2), .valve_spray(vs2), .valve_clean(vc2),
        .valve_agro(va2), .sec_units(su2), .sec_tens(st2), .busy(busy2), .done(done2)
    );

    assign snap1 = {state1, st1, su1, vf1, vd1, vs1, vc1, va1, busy1, done1};
    assign snap2 = {state2, st2, su2, vf2, vd2, vs2, vc2, va2, busy2, done2};

    task automatic checkOutput(input string tag, input snap_t actual, input snap_t expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (state|tens|units|valves|busy|done)",
                     tag, actual, expected);
        end
    endtask

    // Snapshot from the bench's view: seconds in decimal, converted to BCD digits here.
    function automatic snap_t mk(input int st, input int secs, input bit agro,
                                 input bit gated, input bit dn);
        logic [4:0] v;
        v = 5'b0;
        if (!gated) begin
            v[4] = (st == 1);
            v[3] = (st == 2);
            v[2] = (st == 3);
            v[1] = (st == 4);
            v[0] = (st == 3) && agro;
        end
        return {3'(st), 4'(secs / 10), 4'(secs % 10), v, (st != 0), dn};
    endfunction

    task automatic addPhase(input int st, input int t, input bit agro, input int pauseIdx);
        for (int k = 0; k <= t; k++) begin
            for (int c = 0; c < CPS; c++) begin
                if (tmpQ.size() == pauseIdx) begin
                    for (int p = 0; p < 10; p++)
                        tmpQ.push_back(mk(st, t - k, agro, 1'b1, 1'b0));
                end
                tmpQ.push_back(mk(st, t - k, agro, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic buildTrace(input int tF, input int tD, input int tS, input int tC,
                              input bit asp, input bit got, input bit agro, input int pauseIdx);
        tmpQ.delete();
        tmpQ.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
        addPhase(1, tF, agro, pauseIdx);
        if (asp)
            addPhase(3, tS, agro, pauseIdx);
        else if (got)
            addPhase(2, tD, agro, pauseIdx);
        addPhase(4, tC, agro, pauseIdx);
        tmpQ.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
        tmpQ.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    // Starts one cycle; modeClearAt drops both mode inputs before FILL expiry,
    // partial>0 queues only that many leading snapshots.
    task automatic applyStimulus(input string name, input bit second, input bit asp,
                                 input bit got, input bit agro, input int pauseAt,
                                 input int modeClearAt, input int partial);
        int cyc;
        int n;
        bit tAsp, tGot;
        scen = name;
        tAsp = (modeClearAt > 0) ? 1'b0 : asp;
        tGot = (modeClearAt > 0) ? 1'b0 : got;
        @(posedge clk1);
        #1;
        aspersao    = asp;
        gotejamento = got;
        agro_req    = agro;
        if (second) begin
            start2 = 1'b1;
            buildTrace(2, 10, 2, 1, tAsp, tGot, agro, pauseAt);
        end else begin
            start = 1'b1;
            buildTrace(2, 3, 2, 1, tAsp, tGot, agro, pauseAt);
        end
        n = (partial > 0) ? partial : tmpQ.size();
        for (int i = 0; i < n; i++) begin
            if (second) expQ2.push_back(tmpQ[i]);
            else        expQ.push_back(tmpQ[i]);
        end
        cyc = 0;
        while (((second ? expQ2.size() : expQ.size()) != 0) && cyc < 400) begin
            @(posedge clk1);
            #1;
            cyc++;
            if (cyc == 1) agro_req = 1'b0;
            if (cyc == 3) begin
                start  = 1'b0;
                start2 = 1'b0;
            end
            if (pauseAt > 0 && cyc == pauseAt)      pause = 1'b1;
            if (pauseAt > 0 && cyc == pauseAt + 10) pause = 1'b0;
            if (cyc == modeClearAt) begin
                aspersao    = 1'b0;
                gotejamento = 1'b0;
            end
        end
        checkOutput({name, " drain"}, 18'(second ? expQ2.size() : expQ.size()), 18'd0);
        aspersao    = 1'b0;
        gotejamento = 1'b0;
        agro_req    = 1'b0;
        pause       = 1'b0;
        start       = 1'b0;
        start2      = 1'b0;
    endtask

    always @(negedge clk1) begin
        snap_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput({scen, " dut"}, snap1, e);
        end
        if (expQ2.size() != 0) begin
            e = expQ2.pop_front();
            checkOutput({scen, " dutBcd"}, snap2, e);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        start2      = 1'b0;
        gotejamento = 1'b0;
        aspersao    = 1'b0;
        agro_req    = 1'b0;
        pause       = 1'b0;
        #3;
        checkOutput("reset state", snap1, 18'd0);
        checkOutput("reset state dutBcd", snap2, 18'd0);
        repeat (2) @(posedge clk1);
        #1;
        reset = 1'b0;

        applyStimulus("drip",       1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        applyStimulus("drip pause", 1'b0, 1'b0, 1'b1, 1'b0, 18, -1, 0);
        applyStimulus("spray agro", 1'b0, 1'b1, 1'b1, 1'b1, -1, -1, 0);

        scen = "idle start+pause";
        @(posedge clk1);
        #1;
        start = 1'b1;
        pause = 1'b1;
        repeat (4) expQ.push_back(mk(0, 0, 1'b0, 1'b1, 1'b0));
        repeat (4) @(posedge clk1);
        #1;
        start = 1'b0;
        pause = 1'b0;

        applyStimulus("spray reset", 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, 19);
        scen = "reset hold";
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset async", snap1, 18'd0);
        repeat (3) expQ.push_back(18'd0);
        repeat (3) @(posedge clk1);
        #1;
        reset = 1'b0;

        applyStimulus("no mode", 1'b0, 1'b1, 1'b1, 1'b0, -1, 2, 0);
        applyStimulus("bcd borrow", 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 0);

        repeat (2) @(posedge clk1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
